// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: command-driven JTAG master that walks the TAP through
// reset, IR scans and DR scans, capturing TDO into a parallel result.
module jtag_tap_sequencer #(
    parameter int IR_W   = 2,
    parameter int DR_MAX = 128,
    parameter int LEN_W  = 8
) (
    input  logic              CK,
    input  logic              TRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [IR_W-1:0]   ir_val,
    input  logic [LEN_W-1:0]  dr_len,
    input  logic [DR_MAX-1:0] dr_in,
    input  logic              TDO,
    output logic              TMS,
    output logic              TDI,
    output logic              busy,
    output logic              done,
    output logic [DR_MAX-1:0] dr_out
);
    typedef enum logic [3:0] {
        IDLE, TLR_EXIT, RST, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE
    } state_t;

    state_t            state, go_st;
    logic              go, in_tlr;
    logic [1:0]        op_r;
    logic [LEN_W-1:0]  cnt, len_r, len_c;
    logic [IR_W-1:0]   ir_sr;
    logic [DR_MAX-1:0] dr_sr, mask;

    function automatic state_t first_state(input logic [1:0] o, input logic [LEN_W-1:0] n);
        return o == 2'b00 ? RST : o[0] ? IR_HDR : (n != '0) ? DR_HDR : DONE;
    endfunction

    assign len_c = dr_len > LEN_W'(DR_MAX) ? LEN_W'(DR_MAX) : dr_len;

    // Phase entries share one landing point so each phase starts with the same setup.
    always_comb begin
        go    = 1'b0;
        go_st = DONE;
        case (state)
            IDLE: begin
                go    = start;
                go_st = (in_tlr && op != 2'b00) ? TLR_EXIT : first_state(op, len_c);
            end
            TLR_EXIT: begin
                go    = 1'b1;
                go_st = first_state(op_r, len_r);
            end
            RST:     go = cnt == LEN_W'(5);
            IR_TAIL: begin
                go    = cnt == LEN_W'(1);
                go_st = (op_r[1] && len_r != '0) ? DR_HDR : DONE;
            end
            DR_TAIL: go = cnt == LEN_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!TRST) begin
            state  <= IDLE;
            TMS    <= 1'b1;
            TDI    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dr_out <= '0;
            in_tlr <= 1'b1;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TMS <= in_tlr;
                    if (start) begin
                        op_r  <= op;
                        len_r <= len_c;
                        ir_sr <= ir_val;
                        dr_sr <= dr_in;
                    end
                end
                TLR_EXIT: in_tlr <= 1'b0;
                RST: begin
                    cnt <= cnt + 1'b1;
                    TMS <= cnt != LEN_W'(4);
                    if (cnt == LEN_W'(5)) in_tlr <= 1'b0;
                end
                IR_HDR: begin
                    if (cnt == LEN_W'(3)) begin
                        state <= IR_SHIFT;
                        cnt   <= LEN_W'(IR_W);
                        TMS   <= IR_W == 1;
                        TDI   <= ir_sr[0];
                        ir_sr <= ir_sr >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        TMS <= cnt == '0;
                    end
                end
                IR_SHIFT: begin
                    if (cnt == LEN_W'(1)) begin
                        state <= IR_TAIL;
                        cnt   <= '0;
                        TMS   <= 1'b1;
                        TDI   <= 1'b0;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        TMS   <= cnt == LEN_W'(2);
                        TDI   <= ir_sr[0];
                        ir_sr <= ir_sr >> 1;
                    end
                end
                IR_TAIL, DR_TAIL: begin
                    cnt <= cnt + 1'b1;
                    TMS <= 1'b0;
                end
                DR_HDR: begin
                    if (cnt == LEN_W'(2)) begin
                        state <= DR_SHIFT;
                        cnt   <= len_r;
                        TMS   <= len_r == LEN_W'(1);
                        TDI   <= dr_sr[0];
                        dr_sr <= dr_sr >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        TMS <= 1'b0;
                    end
                end
                DR_SHIFT: begin
                    dr_out <= dr_out | (mask & {DR_MAX{TDO}});
                    mask   <= mask << 1;
                    if (cnt == LEN_W'(1)) begin
                        state <= DR_TAIL;
                        cnt   <= '0;
                        TMS   <= 1'b1;
                        TDI   <= 1'b0;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        TMS   <= cnt == LEN_W'(2);
                        TDI   <= dr_sr[0];
                        dr_sr <= dr_sr >> 1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    TMS   <= in_tlr;
                end
                default: state <= IDLE;
            endcase
            if (go) begin
                state <= go_st;
                cnt   <= '0;
                TMS   <= go_st != DONE && go_st != TLR_EXIT;
                TDI   <= 1'b0;
                busy  <= go_st != DONE;
                done  <= go_st == DONE;
                if (go_st == DR_HDR) begin
                    dr_out <= '0;
                    mask   <= {{(DR_MAX-1){1'b0}}, 1'b1};
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: builds the expected TMS/TDI stream of each command
// from the TAP walking rules and compares the DUT cycle by cycle.
module tb_jtag_tap_sequencer;
    localparam int IR_W = 2, DR_MAX = 128, LEN_W = 8;

    logic              CK, TRST, start, TDO, TMS, TDI, busy, done;
    logic [1:0]        op;
    logic [IR_W-1:0]   ir_val;
    logic [LEN_W-1:0]  dr_len;
    logic [DR_MAX-1:0] dr_in, dr_out;

    int errors = 0, checks = 0;
    bit q_tms[$], q_tdi[$], q_cap[$];
    bit m_tlr;
    logic [DR_MAX-1:0] m_dr;

    jtag_tap_sequencer #(.IR_W(IR_W), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
        .CK(CK), .TRST(TRST), .start(start), .op(op), .ir_val(ir_val),
        .dr_len(dr_len), .dr_in(dr_in), .TDO(TDO), .TMS(TMS), .TDI(TDI),
        .busy(busy), .done(done), .dr_out(dr_out)
    );

    initial begin
        CK = 0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string tag, input logic [DR_MAX-1:0] obs, input logic [DR_MAX-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(bit t, bit d, bit c);
        q_tms.push_back(t);
        q_tdi.push_back(d);
        q_cap.push_back(c);
    endfunction

    function automatic logic [DR_MAX-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge with the DUT idle; returns at the idle falling edge after DONE.
    task automatic run_cmd(input logic [1:0] o, input logic [IR_W-1:0] ir, input int len,
                           input logic [DR_MAX-1:0] din, input logic [DR_MAX-1:0] pat,
                           input int poke_at, input int abort_at);
        int n = len > DR_MAX ? DR_MAX : len;
        int k = 0;
        logic [DR_MAX-1:0] keep;
        q_tms.delete(); q_tdi.delete(); q_cap.delete();
        if (o == 2'b00) begin
            repeat (5) push(1, 0, 0);
            push(0, 0, 0);
        end else begin
            if (m_tlr) push(0, 0, 0);
            if (o[0]) begin
                push(1, 0, 0); push(1, 0, 0); push(0, 0, 0); push(0, 0, 0);
                for (int i = 0; i < IR_W; i++) push(i == IR_W - 1, ir[i], 0);
                push(1, 0, 0); push(0, 0, 0);
            end
            if (o[1] && n > 0) begin
                push(1, 0, 0); push(0, 0, 0); push(0, 0, 0);
                for (int i = 0; i < n; i++) push(i == n - 1, din[i], 1);
                push(1, 0, 0); push(0, 0, 0);
            end
        end
        start = 1; op = o; ir_val = ir; dr_len = LEN_W'(len); dr_in = din;
        @(posedge CK);
        for (int i = 0; i < q_tms.size(); i++) begin
            @(negedge CK);
            start = 0;
            chk($sformatf("tms[%0d]", i), TMS, q_tms[i]);
            chk($sformatf("tdi[%0d]", i), TDI, q_tdi[i]);
            chk($sformatf("busy[%0d]", i), busy, 1);
            chk($sformatf("done[%0d]", i), done, 0);
            TDO = q_cap[i] ? pat[k] : 1'($urandom);
            if (q_cap[i]) k++;
            if (i == poke_at) begin
                start = 1; op = ~o; ir_val = ~ir; dr_len = 8'd9; dr_in = ~din;
            end
            if (i == abort_at) begin
                TRST = 0;
                @(negedge CK);
                TRST = 1;
                chk("abort_tms", TMS, 1);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_dr_out", dr_out, 0);
                repeat (5) begin
                    @(negedge CK);
                    chk("abort_no_done", done, 0);
                    chk("abort_idle_tms", TMS, 1);
                end
                m_tlr = 1;
                m_dr = '0;
                return;
            end
        end
        @(negedge CK);
        start = 0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_tms", TMS, 0);
        chk("done_tdi", TDI, 0);
        m_tlr = 0;
        if (o[1] && n > 0) begin
            keep = n == DR_MAX ? '1 : (DR_MAX'(1) << n) - DR_MAX'(1);
            m_dr = pat & keep;
        end
        chk("dr_out", dr_out, m_dr);
        @(negedge CK);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_tms", TMS, 0);
    endtask

    initial begin
        TRST = 0; start = 0; op = 0; ir_val = 0; dr_len = 0; dr_in = 0; TDO = 0;
        m_tlr = 1; m_dr = '0;
        repeat (2) @(negedge CK);
        chk("rst_tms", TMS, 1);
        chk("rst_tdi", TDI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dr_out", dr_out, 0);
        TRST = 1;
        @(negedge CK);
        chk("tlr_idle_tms", TMS, 1);
        run_cmd(2'b00, 2'b00, 0, '0, '0, -1, -1);
        run_cmd(2'b10, 2'b00, 16, rnd128(), rnd128(), -1, -1);
        run_cmd(2'b01, 2'b10, 0, '0, '0, -1, -1);
        run_cmd(2'b11, 2'b01, 4, 128'hB, 128'h6, -1, -1);
        run_cmd(2'b10, 2'b00, 0, rnd128(), rnd128(), -1, -1);
        run_cmd(2'b10, 2'b00, 200, rnd128(), rnd128(), -1, -1);
        run_cmd(2'b11, 2'b11, 32, rnd128(), rnd128(), 5, -1);
        for (int r = 0; r < 10; r++)
            run_cmd(2'($urandom), 2'($urandom), int'($urandom_range(0, 140)), rnd128(), rnd128(), -1, -1);
        run_cmd(2'b10, 2'b00, 64, rnd128(), rnd128(), -1, 30);
        run_cmd(2'b01, 2'b01, 0, '0, '0, -1, -1);
        run_cmd(2'b11, 2'b10, 1, rnd128(), rnd128(), -1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtag_tap_sequencer.md
Name: jtag_tap_sequencer

Overview:
On-chip JTAG master that drives the TMS/TDI pins of a scan-wrapped core's TAP (TAP controller, 2-bit IR, boundary/internal scan registers, bypass) from a simple command interface. Per command it walks the TAP state machine to:
- load an instruction,
- shift a data register of programmable length,
- capture TDO bits into a parallel result.

Sits beside the JTAG top-level in test benches and self-test wrappers, sharing CK and TRST with the TAP.

Parameters:
IR_W, 2, instruction register length in bits
DR_MAX, 128, maximum data-register scan length in bits
LEN_W, 8, width of the dr_len field (2**LEN_W > DR_MAX)

Ports:
CK  input  1  clock shared with the TAP; all state updates on rising edge
TRST  input  1  synchronous, active-low reset (shared with the TAP)
start  input  1  command strobe, accepted only when busy=0
op  input  2  00=TAP reset, 01=IR scan, 10=DR scan, 11=IR then DR scan
ir_val  input  IR_W  instruction to shift, LSB first
dr_len  input  LEN_W  number of DR bits to shift
dr_in  input  DR_MAX  DR shift data, bit 0 shifted first
TDO  input  1  TAP serial output
TMS  output  1  TAP mode select
TDI  output  1  TAP serial data in
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
dr_out  output  DR_MAX  captured TDO bits of the last DR scan, bit k = k-th shifted bit

Behaviour:
- Reset: clock and reset are one clock, synchronous active-low reset (CK, TRST).
- TRST=0 at a rising edge forces:
  - FSM=IDLE, TMS=1, TDI=0, busy=0, done=0, dr_out=0
  - internal flag in_tlr=1 (the TAP is in Test-Logic-Reset).
  - This applies mid-command too: the command is abandoned and no done pulse is issued.
- Command acceptance:
  - start is sampled only in IDLE; op, ir_val, dr_len and dr_in are latched on acceptance.
  - start while busy is ignored.
  - dr_len > DR_MAX is clamped to DR_MAX.
  - op=10/11 with dr_len=0 skips the DR phase.
- TMS/TDI are registered; the value driven in cycle c is consumed by the TAP at the end of c.
- Idle: TMS=0 (parks in Run-Test/Idle) once in_tlr=0, else TMS=1. TDI=0 outside Shift states.
- FSM states: IDLE, TLR_EXIT, RST, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE.
- Prologue: if in_tlr=1 and op!=00, one TLR_EXIT cycle with TMS=0 is issued, then in_tlr clears.
- op=00 (RST): 5 cycles TMS=1, then 1 cycle TMS=0. Ends in Run-Test/Idle, in_tlr=0.
- IR phase:
  - IR_HDR: TMS 1,1,0,0.
  - IR_SHIFT: IR_W cycles, TDI=ir_val[i], TMS=0 except 1 on the last bit.
  - IR_TAIL: TMS 1 (Update-IR), then 0 (Run-Test/Idle).
- DR phase:
  - DR_HDR: TMS 1,0,0.
  - DR_SHIFT: n=dr_len cycles, TDI=dr_in[k], TMS=1 only on bit n-1.
  - DR_TAIL: TMS 1,0.
- TDO capture: in each DR_SHIFT cycle k, TDO is sampled at the closing edge into dr_out[k]. Bits ≥ n are cleared to 0 at DR phase start. dr_out is held until the next DR scan or reset.
- IR scans do not update dr_out.
- op=11 runs the IR phase, then the DR phase back-to-back with no idle cycle.
- Completion: DONE lasts one cycle with done=1, busy=0, TMS=0, then IDLE. A new start is accepted in the DONE cycle's successor.
- Bit counter: LEN_W wide, counts down to 1 with no wrap. An internal shift register holds dr_in.

Test Plan:
- Reset mid-scan: assert TRST=0 during DR_SHIFT of a 64-bit scan -> next cycle TMS=1, busy=0, done never pulses, dr_out=0. Following op=01 is prefixed by one TLR_EXIT cycle.
- IR only: from RTI, op=01, ir_val=2'b10 -> TMS 1,1,0,0,0,1,1,0 with TDI 0 then 1 in the shift cycles. done pulses in cycle 9 after acceptance.
- IR+DR: op=11, ir_val=2'b01, dr_len=4, dr_in=4'b1011, TDO driven as echo pattern 0,1,1,0 -> exactly 17 TMS cycles (8 IR + 9 DR), TDI sequence 1,1,0,1 during DR_SHIFT, dr_out[3:0]=4'b0110.
- Reset op: op=00 -> TMS=1 for exactly 5 cycles then 0, done pulse. The next op=10 has no TLR_EXIT cycle.
- Boundaries:
  - dr_len=0 with op=10 -> no TMS activity beyond RTI, done after 1 cycle, dr_out unchanged.
  - dr_len=200 -> exactly 128 shift cycles.
- start while busy: pulse start with different op/ir_val during a scan -> ignored, original sequence and results unchanged.
